// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the sequential restoring divider.
// Defaults size a 16-bit product divided by an 8-bit known operand.
package div_pkg;

  localparam int DW_DEF    = 16;
  localparam int VW_DEF    = 8;
  localparam int CNT_W_DEF = $clog2(DW_DEF + 1);

  // Quotient reported for a zero divisor: saturated all-ones.
  localparam logic [DW_DEF-1:0] DBZ_QUO_DEF = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, trial-subtract the divisor.
// Purely combinational; the caller registers the new partial remainder.
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW:0]   pr_i,
  input  logic          bit_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW:0]   pr_o,
  output logic          q_o
);

  logic [VW:0] shifted;
  logic [VW:0] trial;

  always_comb begin
    shifted = {pr_i[VW-1:0], bit_i};
    trial   = shifted - {1'b0, divisor_i};
    // A set top bit means the shifted value is already past 2^(VW+1) > divisor;
    // the modular subtraction above still yields the correct remainder then.
    q_o  = pr_i[VW] | (shifted >= {1'b0, divisor_i});
    pr_o = q_o ? trial : shifted;
  end

endmodule

// File: rtl/div_16x8_seq.sv
// Sequential restoring divider: recovers one multiplier operand and a remainder from a product.
// Valid/ready on both sides, one operation in flight, result held until consumed.
module div_16x8_seq
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quo,
  output logic [VW-1:0] rem,
  output logic          dbz,
  output logic          q_fits
);

  localparam int CW = $clog2(DW + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Dividend shifts out at the MSB while quotient bits enter at the LSB.
  logic [DW-1:0] acc_q, acc_d;
  logic [VW:0]   pr_q, pr_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic          zdiv_q, zdiv_d;

  logic          ov_q, ov_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic          fit_q, fit_d;

  logic [VW:0]   step_pr;
  logic          step_q;

  div_step #(.VW(VW)) u_step (
    .pr_i      (pr_q),
    .bit_i     (acc_q[DW-1]),
    .divisor_i (dvs_q),
    .pr_o      (step_pr),
    .q_o       (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    pr_d    = pr_q;
    dvs_d   = dvs_q;
    zdiv_d  = zdiv_q;
    ov_d    = ov_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    fit_d   = fit_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvs_d = divisor;
          if (divisor == '0) begin
            acc_d   = {DW{1'b1}};
            pr_d    = {1'b0, dividend[VW-1:0]};
            zdiv_d  = 1'b1;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            acc_d   = dividend;
            pr_d    = '0;
            zdiv_d  = 1'b0;
            cnt_d   = CW'(DW);
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        acc_d = {acc_q[DW-2:0], step_q};
        pr_d  = step_pr;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // First DONE cycle publishes the working registers into the output stage,
        // so results survive the next accept and stay put while out_ready is low.
        if (!ov_q) begin
          ov_d  = 1'b1;
          quo_d = acc_q;
          rem_d = pr_q[VW-1:0];
          dbz_d = zdiv_q;
          fit_d = !zdiv_q && ((acc_q >> VW) == '0);
        end else if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        ov_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      pr_q    <= '0;
      dvs_q   <= '0;
      zdiv_q  <= 1'b0;
      ov_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      fit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      pr_q    <= pr_d;
      dvs_q   <= dvs_d;
      zdiv_q  <= zdiv_d;
      ov_q    <= ov_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      fit_q   <= fit_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign quo       = quo_q;
  assign rem       = rem_q;
  assign dbz       = dbz_q;
  assign q_fits    = fit_q;

endmodule

// File: tb/tb_div_16x8_seq.sv
// Bench for div_16x8_seq: directed vector table, handshake/reset corner sequences,
// and randomized operands scored against plain integer division.
module tb_div_16x8_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quo;
  logic [7:0]  rem;
  logic        dbz;
  logic        q_fits;

  int n_tests = 0;
  int n_fail  = 0;

  div_16x8_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quo       (quo),
    .rem       (rem),
    .dbz       (dbz),
    .q_fits    (q_fits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] quo;
    logic [7:0]  rem;
    logic        dbz;
    logic        fit;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] quo;
    logic [7:0]  rem;
    logic        dbz;
    logic        fit;
  } exp_t;

  vec_t tbl[9];
  exp_t sb_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at #1 after the accepting edge; counts edges until out_valid.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("out_valid_seen", out_valid, 1);
  endtask

  task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    check("in_ready_after_accept", in_ready, 0);
    wait_result(lat);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_after_hs", out_valid, 0);
    check("in_ready_after_hs", in_ready, 1);
  endtask

  function automatic exp_t model(input logic [15:0] dvd, input logic [7:0] dvs);
    exp_t e;
    int unsigned q;
    e.dvd = dvd;
    e.dvs = dvs;
    if (dvs == 8'd0) begin
      e.quo = 16'hFFFF;
      e.rem = dvd[7:0];
      e.dbz = 1'b1;
      e.fit = 1'b0;
    end else begin
      q     = int'(dvd) / int'(dvs);
      e.quo = 16'(q);
      e.rem = 8'(int'(dvd) % int'(dvs));
      e.dbz = 1'b0;
      e.fit = (q < 256);
    end
    return e;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    exp_t e;
    logic [15:0] rd;
    logic [7:0]  rv;

    tbl[0] = '{16'h9D08, 8'hC9, 16'h00C8, 8'h00, 1'b0, 1'b1, 17};
    tbl[1] = '{16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 1'b1, 17};
    tbl[2] = '{16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 1'b0, 17};
    tbl[3] = '{16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 1'b0, 1};
    tbl[4] = '{16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0, 1'b1, 17};
    tbl[5] = '{16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 1'b0, 17};
    tbl[6] = '{16'hFFFE, 8'hFF, 16'h0100, 8'hFE, 1'b0, 1'b0, 17};
    tbl[7] = '{16'h00FE, 8'hFF, 16'h0000, 8'hFE, 1'b0, 1'b1, 17};
    tbl[8] = '{16'h00FF, 8'hFF, 16'h0001, 8'h00, 1'b0, 1'b1, 17};

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_quo", quo, 0);
    check("rst_rem", rem, 0);
    check("rst_dbz", dbz, 0);
    check("rst_q_fits", q_fits, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].dvd, tbl[i].dvs, lat);
      check("tbl_latency", lat, tbl[i].lat);
      check("tbl_quo", quo, tbl[i].quo);
      check("tbl_rem", rem, tbl[i].rem);
      check("tbl_dbz", dbz, tbl[i].dbz);
      check("tbl_q_fits", q_fits, tbl[i].fit);
      consume();
      check("tbl_quo_held", quo, tbl[i].quo);
    end

    // Stall in DONE with in_valid toggling, then release together with a new request.
    run_op(16'h9D08, 8'hC9, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      dividend = 16'($urandom);
      divisor  = 8'h03;
      @(posedge clk);
      #1;
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_quo", quo, 16'h00C8);
      check("stall_rem", rem, 8'h00);
      check("stall_q_fits", q_fits, 1);
    end
    in_valid  = 1'b1;
    dividend  = 16'h03E8;
    divisor   = 8'h07;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("release_quo_held", quo, 16'h00C8);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("next_accept", in_ready, 0);
    wait_result(lat);
    check("next_latency", lat, 17);
    check("next_quo", quo, 16'h008E);
    check("next_rem", rem, 8'h06);
    consume();

    // Reset in the middle of an iteration sequence.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 16'h9D08;
    divisor  = 8'hC9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_quo", quo, 0);
    check("midrst_rem", rem, 0);
    check("midrst_q_fits", q_fits, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_idle_no_result", out_valid, 0);
    run_op(16'h9D08, 8'hC9, lat);
    check("postrst_latency", lat, 17);
    check("postrst_quo", quo, 16'h00C8);
    check("postrst_rem", rem, 8'h00);
    check("postrst_dbz", dbz, 0);
    consume();

    // Random operands against the arithmetic reference, through a scoreboard queue.
    for (int n = 0; n < 2000; n++) begin
      rd = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rd = rd >> $urandom_range(4, 12);
      rv = 8'($urandom);
      if ($urandom_range(0, 15) == 0) rv = 8'd0;
      sb_q.push_back(model(rd, rv));
      run_op(rd, rv, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("rnd_latency", lat, e.dbz ? 1 : 17);
      check("rnd_quo", quo, e.quo);
      check("rnd_rem", rem, e.rem);
      check("rnd_dbz", dbz, e.dbz);
      check("rnd_q_fits", q_fits, e.fit);
      if (!e.dbz) begin
        check("rnd_identity", int'(quo) * int'(e.dvs) + int'(rem), int'(e.dvd));
      end
      consume();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
